// File: rtl/axis_1553_pkg.sv
// Shared definitions for the axis_1553 encoder/decoder pair: sync codes, tuser layout,
// line-level codes, decoder state encoding and half-bit timing derivation.
package axis_1553_pkg;

  localparam logic [1:0] SYNC_CMD  = 2'b10;
  localparam logic [1:0] SYNC_DATA = 2'b01;

  localparam logic [1:0] LINE_HI  = 2'b10;
  localparam logic [1:0] LINE_LO  = 2'b01;
  localparam logic [1:0] LINE_INV = 2'b00;

  localparam int TU_SYNC_HI = 7;
  localparam int TU_SYNC_LO = 6;
  localparam int TU_OVR     = 2;
  localparam int TU_MERR    = 1;
  localparam int TU_PAR_OK  = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC2 = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  // 1553 runs at 1 Mbit/s, so one half-bit lasts 500 ns.
  function automatic int hb_clks(input int clock_speed);
    return clock_speed / 2000000;
  endfunction

  function automatic logic is_valid(input logic [1:0] lvl);
    return (lvl == LINE_HI) || (lvl == LINE_LO);
  endfunction

endpackage

// File: rtl/axis_1553_dec_sampler.sv
// Line front end for the 1553 decoder: two-flop synchronizer, HI<->LO transition
// detect, and a saturating run counter of the level seen before the current sample.
module axis_1553_dec_sampler
  import axis_1553_pkg::*;
#(
  parameter int CLOCK_SPEED = 20000000
) (
  input  logic                                       aclk,
  input  logic                                       arst,
  input  logic [1:0]                                 diff,
  output logic [1:0]                                 line,
  output logic                                       trans,
  output logic [$clog2(5*hb_clks(CLOCK_SPEED)+1)-1:0] run
);
  localparam int HB = hb_clks(CLOCK_SPEED);
  localparam int RW = $clog2(5 * HB + 1);
  localparam logic [RW-1:0] RUN_SAT = RW'(5 * HB);

  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    sync1_d = diff;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    trans   = ((sync2_q == LINE_HI) && (prev_q == LINE_LO)) ||
              ((sync2_q == LINE_LO) && (prev_q == LINE_HI));
    // run_q ends up holding the length of the level that just ended when trans fires.
    if (!is_valid(sync2_q))  run_d = '0;
    else if (trans)          run_d = RW'(1);
    else if (run_q == RUN_SAT) run_d = run_q;
    else                     run_d = run_q + RW'(1);
  end

  always_ff @(posedge aclk) begin
    // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
    if (arst) begin
      sync1_q <= LINE_INV;
      sync2_q <= LINE_INV;
      prev_q  <= LINE_INV;
      run_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
    end
  end

  assign line = sync2_q;
  assign run  = run_q;

endmodule

// File: rtl/axis_1553_decoder.sv
// MIL-STD-1553 Manchester II receiver emitting one AXIS beat per 20-bit word.
// Define DEC_ERR_REPORT_EN to emit Manchester-error words (tuser[1]=1) instead of dropping them.
module axis_1553_decoder
  import axis_1553_pkg::*;
#(
  parameter int CLOCK_SPEED = 20000000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);
  localparam int HB = hb_clks(CLOCK_SPEED);
  localparam int RW = $clog2(5 * HB + 1);

  localparam logic [RW-1:0] RUN_MIN   = RW'((5 * HB) / 2);
  localparam logic [RW-1:0] RUN_LIM   = RW'((9 * HB) / 2);
  localparam logic [RW-1:0] SAMPLE_0  = RW'(HB / 2);
  localparam logic [RW-1:0] SYNC_S1   = RW'((3 * HB) / 2);
  localparam logic [RW-1:0] SYNC_S2   = RW'((5 * HB) / 2);
  localparam logic [RW-1:0] SYNC_LAST = RW'(3 * HB - 1);
  localparam logic [RW-1:0] HB_LAST   = RW'(HB - 1);
  localparam logic [4:0]    LAST_BIT  = 5'd16;

`ifdef DEC_ERR_REPORT_EN
  localparam logic ERR_REPORT = 1'b1;
`else
  localparam logic ERR_REPORT = 1'b0;
`endif

  logic [1:0]    line;
  logic          trans;
  logic [RW-1:0] run;

  axis_1553_dec_sampler #(.CLOCK_SPEED(CLOCK_SPEED)) u_sampler (
    .aclk  (aclk),
    .arst  (arst),
    .diff  (diff),
    .line  (line),
    .trans (trans),
    .run   (run)
  );

  logic [1:0]    state_q, state_d, sync_q, sync_d, first_q, first_d, opp_level;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d, err_q, err_d, ovr_q, ovr_d;
  logic [4:0]    bit_q, bit_d;
  logic [16:0]   shift_q, shift_d;
  logic [15:0]   tdata_q, tdata_d;
  logic [7:0]    tuser_q, tuser_d, tuser_new;
  logic          tvalid_q, tvalid_d;
  logic          word_done, bit_val, bit_bad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    bit_d     = bit_q;
    first_d   = first_q;
    shift_d   = shift_q;
    sync_d    = sync_q;
    err_d     = err_q;
    word_done = 1'b0;
    bit_val   = 1'b0;
    bit_bad   = 1'b0;
    opp_level = (sync_q == SYNC_CMD) ? LINE_LO : LINE_HI;

    case (state_q)
      ST_IDLE: begin
        // The edge cycle counts as position 0, so the counter resumes at 1.
        if (trans && (run >= RUN_MIN) && (run <= RUN_LIM)) begin
          state_d = ST_SYNC2;
          cnt_d   = RW'(1);
          sync_d  = (line == LINE_LO) ? SYNC_CMD : SYNC_DATA;
          err_d   = 1'b0;
        end
      end
      ST_SYNC2: begin
        cnt_d = cnt_q + RW'(1);
        if (((cnt_q == SAMPLE_0) || (cnt_q == SYNC_S1) || (cnt_q == SYNC_S2)) && (line != opp_level)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + RW'(1);
        if (cnt_q == HB_LAST) begin
          cnt_d  = '0;
          half_d = ~half_q;
        end
        // A transition near mid-bit marks the start of the second half: resync to it.
        if (trans && (half_q ? (cnt_q < SAMPLE_0) : (cnt_q > SAMPLE_0))) begin
          cnt_d  = RW'(1);
          half_d = 1'b1;
        end
        if (cnt_q == SAMPLE_0) begin
          if (!half_q) begin
            first_d = line;
          end else begin
            bit_val = (first_q == LINE_HI) && (line == LINE_LO);
            bit_bad = !(bit_val || ((first_q == LINE_LO) && (line == LINE_HI)));
            shift_d = {shift_q[15:0], bit_val};
            err_d   = err_q | bit_bad;
            bit_d   = bit_q + 5'd1;
            if (bit_bad && !ERR_REPORT) begin
              state_d = ST_IDLE;
            end else if (bit_q == LAST_BIT) begin
              word_done = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tvalid_d  = tvalid_q;
    ovr_d     = ovr_q;
    tuser_new = '0;
    tuser_new[TU_SYNC_HI:TU_SYNC_LO] = sync_q;
    tuser_new[TU_OVR]    = ovr_q;
    tuser_new[TU_MERR]   = err_d & ERR_REPORT;
    tuser_new[TU_PAR_OK] = ^shift_d;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
    if (word_done) begin
      if (tvalid_q && !m_axis_tready) begin
        ovr_d = 1'b1;
      end else begin
        tdata_d  = shift_d[16:1];
        tuser_d  = tuser_new;
        tvalid_d = 1'b1;
        ovr_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      half_q   <= 1'b0;
      bit_q    <= '0;
      first_q  <= LINE_INV;
      shift_q  <= '0;
      sync_q   <= SYNC_DATA;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      first_q  <= first_d;
      shift_q  <= shift_d;
      sync_q   <= sync_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_1553_decoder.sv
// Self-checking bench for axis_1553_decoder: table of words plus hand-written overrun and reset sequences.
module tb_axis_1553_decoder;
  localparam int HB = 10;
  localparam logic [1:0] HI = 2'b10, LO = 2'b01, INV = 2'b00;
  localparam logic [1:0] CMD = 2'b10, DAT = 2'b01;
`ifdef DEC_ERR_REPORT_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        arst;
  logic [1:0]  diff;
  logic [15:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tready;

  axis_1553_decoder #(.CLOCK_SPEED(20000000)) dut (
    .aclk          (aclk),
    .arst          (arst),
    .diff          (diff),
    .m_axis_tdata  (tdata),
    .m_axis_tuser  (tuser),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    logic [1:0]  sync;
    logic [15:0] data;
    logic        par;
    int          bad;
    int          gap;
    logic        beat;
    logic [15:0] exp_data;
    logic [7:0]  exp_user;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[7];
  int    n_tests = 0;
  int    n_fail = 0;
  int    beats = 0;
  int    exp_beats = 0;
  int    glitches = 0;
  int    beats_mark = 0;
  logic  hold_watch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [1:0] sync, input logic [15:0] data, input logic par,
                           input int bad, input int nbits);
    logic [16:0] bits;
    bits = {data, par};
    diff = (sync == CMD) ? HI : LO;
    repeat (3 * HB) tick();
    diff = (sync == CMD) ? LO : HI;
    repeat (3 * HB) tick();
    for (int i = 0; i < nbits; i++) begin
      diff = (i == bad) ? HI : (bits[16-i] ? HI : LO);
      repeat (HB) tick();
      diff = (i == bad) ? HI : (bits[16-i] ? LO : HI);
      repeat (HB) tick();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (tvalid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(name, tvalid, 1'b1);
  endtask

  // Scoreboard: every handshake pops one expected beat.
  always @(negedge aclk) begin
    if (!arst && tvalid && tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got tdata=0x%0h tuser=0x%0h, expected no beat", tdata, tuser);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_tdata", tdata, e.data);
        check("beat_tuser", tuser, e.user);
      end
    end
    if (hold_watch && (tvalid !== 1'b1 || tdata !== 16'h1111 || tuser !== 8'h81)) glitches++;
  end

  initial begin
    arst = 1'b1;
    diff = INV;
    tready = 1'b1;
    repeat (3) tick();
    check("reset_tvalid", tvalid, 1'b0);
    check("reset_tdata", tdata, 16'h0000);
    check("reset_tuser", tuser, 8'h00);
    arst = 1'b0;
    repeat (5) tick();

    vecs[0] = '{CMD, 16'h1234, 1'b0, -1, 4, 1'b1,   16'h1234, 8'h81};
    vecs[1] = '{DAT, 16'hFFFF, 1'b1, -1, 4, 1'b1,   16'hFFFF, 8'h41};
    vecs[2] = '{CMD, 16'h0001, 1'b1, -1, 4, 1'b1,   16'h0001, 8'h80};
    vecs[3] = '{CMD, 16'hFFFF, 1'b1,  5, 4, ERR_EN, 16'hFBFF, 8'h82};
    vecs[4] = '{DAT, 16'hA5C3, 1'b1, -1, 0, 1'b1,   16'hA5C3, 8'h41};
    vecs[5] = '{CMD, 16'h0000, 1'b1, -1, 0, 1'b1,   16'h0000, 8'h81};
    vecs[6] = '{DAT, 16'h8000, 1'b0, -1, 4, 1'b1,   16'h8000, 8'h41};

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].beat) begin
        exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_user});
        exp_beats++;
      end
      send_word(vecs[i].sync, vecs[i].data, vecs[i].par, vecs[i].bad, 17);
      if (vecs[i].gap > 0) begin
        diff = INV;
        repeat (vecs[i].gap * HB) tick();
        drain($sformatf("vec%0d", i));
      end
    end
    check("table_beats", beats, exp_beats);

    // Overrun: first word held while two more complete with tready low.
    tready = 1'b0;
    exp_q.push_back('{16'h1111, 8'h81});
    exp_beats++;
    fork
      begin
        send_word(CMD, 16'h1111, 1'b1, -1, 17);
        send_word(DAT, 16'h2222, 1'b1, -1, 17);
        send_word(CMD, 16'h3333, 1'b1, -1, 17);
        diff = INV;
      end
      begin
        wait_valid("ovr_first_valid");
        hold_watch = 1'b1;
      end
    join
    repeat (5) tick();
    check("ovr_hold_glitches", glitches, 0);
    check("ovr_still_valid", tvalid, 1'b1);
    hold_watch = 1'b0;
    tready = 1'b1;
    drain("ovr_first");
    exp_q.push_back('{16'h0F0F, 8'h45});
    exp_beats++;
    send_word(DAT, 16'h0F0F, 1'b1, -1, 17);
    diff = INV;
    repeat (4 * HB) tick();
    drain("ovr_flagged");

    // Reset mid data bit 8 while a beat is held.
    tready = 1'b0;
    send_word(CMD, 16'h1234, 1'b0, -1, 17);
    diff = INV;
    wait_valid("rst_held_valid");
    beats_mark = beats;
    send_word(DAT, 16'hABCD, 1'b0, -1, 8);
    diff = HI;
    repeat (HB / 2) tick();
    arst = 1'b1;
    tick();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 16'h0000);
    check("rst_tuser", tuser, 8'h00);
    arst = 1'b0;
    diff = INV;
    tready = 1'b1;
    repeat (60) tick();
    check("rst_no_beat", beats, beats_mark);
    exp_q.push_back('{16'h00FF, 8'h41});
    exp_beats++;
    send_word(DAT, 16'h00FF, 1'b1, -1, 17);
    diff = INV;
    repeat (4 * HB) tick();
    drain("rst_recover");

    check("final_beats", beats, exp_beats);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
